// File: rtl/regfile_write_queue_if.sv
// Request-side and issue-side signals of the register-file write queue.
// The master drives requests and hold; the slave (the queue) drives ready and the issued strobe.
interface regfile_write_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              hold;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_addr, in_data, hold,
        input  in_ready, wr_en, wr_addr, wr_data, count
    );

    modport slave (
        input  in_valid, in_addr, in_data, hold,
        output in_ready, wr_en, wr_addr, wr_data, count
    );
endinterface

// File: rtl/regfile_write_queue.sv
// Write-request FIFO feeding the register-file 3:8 write decoder.
// Each accepted request becomes exactly one registered wr_en strobe, in strict FIFO order.
module regfile_write_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    regfile_write_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              ready;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    // Ready depends only on the registered count, so a full queue refuses a push even on a pop edge.
    assign ready = (count_q < CNT_W'(DEPTH)) && !reset;
    assign push  = bus.in_valid && ready;
    assign pop   = (count_q != '0) && !bus.hold;

    assign {head_addr, head_data} = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            wr_en_d   = 1'b1;
            wr_addr_d = head_addr;
            wr_data_d = head_data;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Storage is never reset; count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_addr, bus.in_data};
        end
    end

    assign bus.in_ready = ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.count    = count_q;
endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue: reset, single write, streaming, fill under hold,
// steady push/pop with pointer wrap, and reset in mid-operation.
module tb_regfile_write_queue;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    regfile_write_queue_if #(.DEPTH(4), .ADDR_W(3), .DATA_W(32)) bus ();

    regfile_write_queue #(.DEPTH(4), .ADDR_W(3), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [2:0] a, input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.hold     = 1'b0;

        // Reset asserted mid-cycle clears outputs immediately.
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_wr_en",    64'(bus.wr_en),    64'd0);
        chk("rst_wr_addr",  64'(bus.wr_addr),  64'd0);
        chk("rst_wr_data",  64'(bus.wr_data),  64'd0);
        chk("rst_count",    64'(bus.count),    64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_wr_en", 64'(bus.wr_en), 64'd0);
        end

        // Single write: accepted at edge t, strobe during the cycle after t+1.
        present(3'd5, 32'hDEADBEEF);
        tick();
        bus.in_valid = 1'b0;
        chk("single_wr_en_t",  64'(bus.wr_en), 64'd0);
        chk("single_count_t",  64'(bus.count), 64'd1);
        tick();
        chk("single_wr_en",   64'(bus.wr_en),   64'd1);
        chk("single_wr_addr", 64'(bus.wr_addr), 64'd5);
        chk("single_wr_data", 64'(bus.wr_data), 64'hDEADBEEF);
        chk("single_count",   64'(bus.count),   64'd0);
        tick();
        chk("single_wr_en_off", 64'(bus.wr_en),   64'd0);
        chk("single_addr_kept", 64'(bus.wr_addr), 64'd5);

        // Streaming: push every cycle, issue lags by one, count stays at 1.
        for (int i = 0; i < 8; i++) begin
            present(3'(i), 32'h100 + 32'(i));
            tick();
            chk("stream_count", 64'(bus.count), 64'd1);
            if (i == 0) begin
                chk("stream_first_en", 64'(bus.wr_en), 64'd0);
            end else begin
                chk("stream_wr_en",   64'(bus.wr_en),   64'd1);
                chk("stream_wr_addr", 64'(bus.wr_addr), 64'(i - 1));
                chk("stream_wr_data", 64'(bus.wr_data), 64'h100 + 64'(i - 1));
            end
        end
        bus.in_valid = 1'b0;
        tick();
        chk("stream_last_en",   64'(bus.wr_en),   64'd1);
        chk("stream_last_addr", 64'(bus.wr_addr), 64'd7);
        chk("stream_count_end", 64'(bus.count),   64'd0);
        tick();
        chk("stream_en_off", 64'(bus.wr_en), 64'd0);

        // Fill under hold: four accepted, the fifth (addr 6) must wait.
        bus.hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            present(3'(i), 32'h200 + 32'(i));
            chk("fill_ready", 64'(bus.in_ready), 64'd1);
            tick();
            chk("fill_count", 64'(bus.count), 64'(i));
            chk("fill_wr_en", 64'(bus.wr_en), 64'd0);
        end
        present(3'd6, 32'h206);
        chk("full_ready", 64'(bus.in_ready), 64'd0);
        tick();
        chk("full_count_held", 64'(bus.count),    64'd4);
        chk("full_ready_held", 64'(bus.in_ready), 64'd0);
        chk("full_wr_en_held", 64'(bus.wr_en),    64'd0);
        bus.hold = 1'b0;
        tick();
        chk("drain1_en",    64'(bus.wr_en),    64'd1);
        chk("drain1_addr",  64'(bus.wr_addr),  64'd1);
        chk("drain1_count", 64'(bus.count),    64'd3);
        chk("drain1_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("drain2_addr",  64'(bus.wr_addr), 64'd2);
        chk("drain2_count", 64'(bus.count),   64'd3);
        present(3'd7, 32'h207);
        tick();
        chk("drain3_addr",  64'(bus.wr_addr), 64'd3);
        chk("drain3_count", 64'(bus.count),   64'd3);
        bus.in_valid = 1'b0;
        tick();
        chk("drain4_addr",  64'(bus.wr_addr), 64'd4);
        chk("drain4_count", 64'(bus.count),   64'd2);
        tick();
        chk("drain6_en",   64'(bus.wr_en),   64'd1);
        chk("drain6_addr", 64'(bus.wr_addr), 64'd6);
        chk("drain6_data", 64'(bus.wr_data), 64'h206);
        tick();
        chk("drain7_addr", 64'(bus.wr_addr), 64'd7);
        chk("drain7_data", 64'(bus.wr_data), 64'h207);
        tick();
        chk("drain_en_off",    64'(bus.wr_en), 64'd0);
        chk("drain_count_end", 64'(bus.count), 64'd0);

        // Steady push/pop at count=2 for 12 cycles; pointers wrap repeatedly.
        bus.hold = 1'b1;
        present(3'd0, 32'h300);
        tick();
        present(3'd1, 32'h301);
        tick();
        chk("pp_prefill_count", 64'(bus.count), 64'd2);
        bus.hold = 1'b0;
        for (int k = 0; k < 12; k++) begin
            present(3'((k + 2) % 8), 32'h300 + 32'(k + 2));
            tick();
            chk("pp_count",   64'(bus.count),   64'd2);
            chk("pp_wr_en",   64'(bus.wr_en),   64'd1);
            chk("pp_wr_addr", 64'(bus.wr_addr), 64'(k % 8));
            chk("pp_wr_data", 64'(bus.wr_data), 64'h300 + 64'(k));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("pp_tail12", 64'(bus.wr_data), 64'h30C);
        tick();
        chk("pp_tail13", 64'(bus.wr_data), 64'h30D);
        chk("pp_tail13_addr", 64'(bus.wr_addr), 64'd5);
        tick();
        chk("pp_en_off", 64'(bus.wr_en), 64'd0);

        // Reset mid-operation with count=3 and a strobe in flight.
        bus.hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            present(3'(i), 32'h400 + 32'(i));
            tick();
        end
        bus.in_valid = 1'b0;
        bus.hold     = 1'b0;
        tick();
        chk("mid_wr_en",  64'(bus.wr_en),   64'd1);
        chk("mid_addr",   64'(bus.wr_addr), 64'd1);
        chk("mid_count",  64'(bus.count),   64'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("mid_rst_count", 64'(bus.count), 64'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_wr_en", 64'(bus.wr_en), 64'd0);
            chk("post_rst_count", 64'(bus.count), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
